// File: rtl/decisiontree_loader.sv
// Decision-tree node RAM writer: assembles 5-byte records from a byte stream,
// validates them and writes them to consecutive node addresses starting at 1.
module decisiontree_loader #(
    parameter int unsigned DATA  = 8,
    parameter int unsigned STATE = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        load_start_i,
    input  logic [STATE-1:0]                            node_cnt_i,
    input  logic [7:0]                                  byte_i,
    input  logic                                        byte_valid_i,
    output logic                                        byte_ready_o,
    output logic                                        wr_en_o,
    output logic [STATE-1:0]                            wr_addr_o,
    output logic [STATE+1+DATA+STATE+STATE+DATA-1:0]    wr_data_o,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        err_o
);

    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StErr} state_e;

    state_e                                     state_q, state_d;
    logic [2:0]                                 idx_q, idx_d;
    logic [STATE-1:0]                           addr_q, addr_d;
    logic [STATE-1:0]                           cnt_q, cnt_d;
    logic [7:0]                                 hdr_q, hdr_d;
    logic [DATA-1:0]                            data_q, data_d;
    logic [STATE-1:0]                           nt_q, nt_d;
    logic [STATE-1:0]                           nf_q, nf_d;
    logic                                       ready_q, ready_d;
    logic                                       busy_q, busy_d;
    logic                                       done_q, done_d;
    logic                                       err_q, err_d;
    logic                                       wr_en_q, wr_en_d;
    logic [STATE-1:0]                           wr_addr_q, wr_addr_d;
    logic [STATE+1+DATA+STATE+STATE+DATA-1:0]   wr_data_q, wr_data_d;

    logic accept;
    logic rec_ok;

    assign accept = byte_valid_i & ready_q;

    // Slots 0..3 are already stored when the y byte arrives, so the record can
    // be judged in the same cycle and the strobe registered into WRITE.
    assign rec_ok = (hdr_q[7:1] == 7'd0) &&
                    (hdr_q[0] || ((nt_q != '0) && (nf_q != '0) &&
                                  (nt_q <= cnt_q) && (nf_q <= cnt_q)));

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        nt_d      = nt_q;
        nf_d      = nf_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            StIdle, StErr: begin
                if (load_start_i) begin
                    if (node_cnt_i != '0) begin
                        cnt_d   = node_cnt_i;
                        addr_d  = STATE'(1);
                        idx_d   = 3'd0;
                        err_d   = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StRecv;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
            end
            StRecv: begin
                if (accept) begin
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd0:    hdr_d  = byte_i;
                        3'd1:    data_d = byte_i[DATA-1:0];
                        3'd2:    nt_d   = byte_i[STATE-1:0];
                        3'd3:    nf_d   = byte_i[STATE-1:0];
                        default: begin
                            ready_d   = 1'b0;
                            wr_en_d   = rec_ok;
                            wr_addr_d = addr_q;
                            wr_data_d = {{STATE{1'b0}}, hdr_q[0], data_q, nt_q, nf_q,
                                         byte_i[DATA-1:0]};
                            state_d   = StWrite;
                        end
                    endcase
                end
            end
            StWrite: begin
                // wr_en_q doubles as the registered validity of this record
                if (wr_en_q) begin
                    if (addr_q == cnt_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + STATE'(1);
                        idx_d   = 3'd0;
                        ready_d = 1'b1;
                        state_d = StRecv;
                    end
                end else begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StErr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            addr_q    <= STATE'(1);
            cnt_q     <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            nt_q      <= '0;
            nf_q      <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            nt_q      <= nt_d;
            nf_q      <= nf_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_decisiontree_loader.sv
// Self-checking bench for decisiontree_loader: a stream-level model predicts
// the node writes and outcome; a monitor checks every strobe against it.
module tb_decisiontree_loader;

    localparam int unsigned DATA  = 8;
    localparam int unsigned STATE = 8;
    localparam int unsigned WW    = STATE + 1 + DATA + STATE + STATE + DATA;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_start_i = 1'b0;
    logic [STATE-1:0] node_cnt_i = '0;
    logic [7:0]       byte_i = '0;
    logic             byte_valid_i = 1'b0;
    logic             byte_ready_o;
    logic             wr_en_o;
    logic [STATE-1:0] wr_addr_o;
    logic [WW-1:0]    wr_data_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    decisiontree_loader #(.DATA(DATA), .STATE(STATE)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start_i (load_start_i),
        .node_cnt_i   (node_cnt_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [STATE-1:0] addr;
        logic [WW-1:0]    data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cycle = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         n_obs = 0;
    int         obs_cyc[16];
    logic [WW-1:0]    obs_data[16];
    logic [STATE-1:0] obs_addr[16];
    int         exp_consumed;
    bit         exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Stream-level model: walk stim_q node by node and list the writes the
    // loader must issue, stopping at the first invalid record.
    task automatic model(input int cnt);
        int p;
        logic [7:0] h, d, t, f, y;
        p = 0;
        exp_q.delete();
        exp_err = 1'b0;
        if (cnt == 0) begin
            exp_err = 1'b1;
        end else begin
            for (int n = 1; n <= cnt; n++) begin
                if (p + 5 > stim_q.size()) break;
                h = stim_q[p];
                d = stim_q[p+1];
                t = stim_q[p+2];
                f = stim_q[p+3];
                y = stim_q[p+4];
                p += 5;
                if (h[7:1] != 7'd0 ||
                    (!h[0] && (t == 0 || f == 0 || int'(t) > cnt || int'(f) > cnt))) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_q.push_back({n[STATE-1:0], {8'h00, h[0], d, t, f, y}});
            end
        end
        exp_consumed = p;
    endtask

    // Monitor: every strobe must match the head of the expected-write queue
    always @(negedge clk) begin
        wr_t e;
        cycle++;
        if (wr_en_o) begin
            if (n_obs < 16) begin
                obs_cyc[n_obs]  = cycle;
                obs_data[n_obs] = wr_data_o;
                obs_addr[n_obs] = wr_addr_o;
            end
            n_obs++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         wr_addr_o, wr_data_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr_o), 64'(e.addr));
                check("wr_data", 64'(wr_data_o), 64'(e.data));
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cycle;
        end
    end

    task automatic clear_obs();
        n_obs    = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start(input int cnt);
        @(negedge clk);
        load_start_i = 1'b1;
        node_cnt_i   = cnt[STATE-1:0];
        @(negedge clk);
        load_start_i = 1'b0;
        node_cnt_i   = '0;
    endtask

    // Present stim_q[0..nbytes-1]; a byte counts as taken when ready is high
    // across the following posedge.
    task automatic feed(input int nbytes, input bit gaps);
        int  i;
        int  guard;
        bit  ph;
        i = 0;
        guard = 0;
        ph = 1'b0;
        while (i < nbytes && guard < 300) begin
            if (gaps && ph) begin
                byte_valid_i = 1'b0;
            end else begin
                byte_valid_i = 1'b1;
                byte_i = stim_q[i];
                if (byte_ready_o) i++;
            end
            ph = ~ph;
            guard++;
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        if (i < nbytes) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: got %0d bytes accepted, required %0d", i, nbytes);
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        check({tag, "_err"}, 64'(err_o), 64'(exp_err));
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({byte_ready_o, wr_en_o, busy_o, done_o, err_o}), 64'd0);
        reset = 1'b1;

        // 1: three-node tree, valid held high
        stim_q = '{8'h00, 8'h10, 8'h02, 8'h03, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'hAA,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
        model(3);
        clear_obs();
        start(3);
        check("t1_busy_in_recv", 64'({busy_o, byte_ready_o}), 64'b11);
        feed(exp_consumed, 1'b0);
        settle_and_check("t1");
        check("t1_nwrites", 64'(n_obs), 64'd3);
        check("t1_spacing12", 64'(obs_cyc[1] - obs_cyc[0]), 64'd6);
        check("t1_spacing23", 64'(obs_cyc[2] - obs_cyc[1]), 64'd6);
        check("t1_done_lag", 64'(done_cyc - obs_cyc[2]), 64'd1);
        check("t1_lit_node1", 64'(obs_data[0]),
              64'({8'h00, 1'b0, 8'h10, 8'h02, 8'h03, 8'h00}));
        check("t1_lit_node2", 64'(obs_data[1]),
              64'({8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'hAA}));
        check("t1_lit_addr3", 64'(obs_addr[2]), 64'd3);
        check("t1_lit_y3", 64'(obs_data[2][7:0]), 64'h55);

        // 2: same stream with valid gaps
        model(3);
        clear_obs();
        start(3);
        feed(exp_consumed, 1'b1);
        settle_and_check("t2");
        check("t2_nwrites", 64'(n_obs), 64'd3);

        // 3: bad pointer, then recovery from ERR
        stim_q = '{8'h00, 8'h10, 8'h02, 8'h03, 8'h00};
        model(2);
        clear_obs();
        start(2);
        feed(exp_consumed, 1'b0);
        settle_and_check("t3a");
        check("t3a_nwrites", 64'(n_obs), 64'd0);
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
        model(1);
        clear_obs();
        start(1);
        check("t3b_err_cleared", 64'(err_o), 64'd0);
        feed(exp_consumed, 1'b0);
        settle_and_check("t3b");
        check("t3b_lit_addr", 64'(obs_addr[0]), 64'd1);
        check("t3b_lit_y", 64'(obs_data[0][7:0]), 64'h07);

        // 4: non-zero reserved header bits
        stim_q = '{8'h02, 8'h10, 8'h02, 8'h03, 8'h00};
        model(3);
        clear_obs();
        start(3);
        feed(exp_consumed, 1'b0);
        settle_and_check("t4");
        check("t4_nwrites", 64'(n_obs), 64'd0);

        // 5: reset in the middle of node 2
        stim_q = '{8'h00, 8'h10, 8'h02, 8'h03, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'hAA};
        model(3);
        clear_obs();
        start(3);
        feed(8, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_pre_reset_writes", 64'(n_obs), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_reset_outputs", 64'({byte_ready_o, wr_en_o, busy_o, done_o, err_o}), 64'd0);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t5_post_reset_writes", 64'(n_obs), 64'd1);
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
        model(1);
        clear_obs();
        start(1);
        feed(exp_consumed, 1'b0);
        settle_and_check("t5");
        check("t5_lit_addr", 64'(obs_addr[0]), 64'd1);

        // 6: zero node count
        stim_q.delete();
        model(0);
        clear_obs();
        start(0);
        for (int k = 0; k < 3; k++) begin
            check("t6_ready_low", 64'(byte_ready_o), 64'd0);
            @(negedge clk);
        end
        settle_and_check("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decisiontree_loader.md
Name: decisiontree_loader

Overview:
- Writer side of the decision-tree node RAM. The evaluator reads this RAM.
- Accepts a byte stream over a valid/ready handshake and assembles each 5-byte group into one node record.
- Validates every record, then writes it to consecutive node addresses starting at 1. Address 0 is the evaluator's idle state and is never written.
- Reports done or error to the host sequencer.

Parameters:
- DATA, 8, width of compare value and output value.
- STATE, 8, width of node address / next-state pointer.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- load_start_i  input  1  one-cycle request to begin a load; sampled in IDLE or ERR only
- node_cnt_i  input  STATE  number of nodes to load; sampled with load_start_i
- byte_i  input  8  stream data
- byte_valid_i  input  1  byte_i valid
- byte_ready_o  output  1  loader can accept a byte
- wr_en_o  output  1  RAM write strobe
- wr_addr_o  output  STATE  RAM write address
- wr_data_o  output  STATE+1+DATA+STATE+STATE+DATA  node word, laid out {STATE'b0, dec, data, next_T, next_F, y}
- busy_o  output  1  load in progress
- done_o  output  1  one-cycle pulse on successful completion
- err_o  output  1  sticky error flag

Behaviour:
- Reset (reset==0 at posedge clk):
  - FSM goes to IDLE.
  - All outputs 0, byte index 0, address 1.
  - Any partially assembled node is discarded and no write is issued.
  - Reset has priority over every other event.
- Byte format, in stream order:
  - b0 = header: bit0 = dec; bits[7:1] must be 0.
  - b1 = data, b2 = next_T, b3 = next_F, b4 = y.
- Width rules:
  - With DATA≠8 or STATE≠8, the low DATA/STATE bits of each byte are used and the excess bits are ignored.
  - Upper STATE bits of wr_data_o are always 0.
- IDLE:
  - byte_ready_o=0, busy_o=0.
  - On load_start_i=1 with node_cnt_i≠0: latch cnt, set addr=1 and idx=0, clear err_o, go to RECV.
  - On load_start_i=1 with node_cnt_i==0: set err_o=1, go to ERR.
- RECV:
  - byte_ready_o=1, busy_o=1.
  - A byte is accepted on a posedge with byte_valid_i & byte_ready_o. It is stored in slot idx and idx increments.
  - Gaps in byte_valid_i stall RECV indefinitely.
  - On acceptance of the byte for idx==4, go to WRITE.
  - load_start_i is ignored in RECV and WRITE.
- WRITE (exactly one cycle):
  - byte_ready_o=0.
  - Validate the assembled record. It is invalid if:
    - header bits[7:1]≠0; or
    - dec==0 and any of next_T==0, next_F==0, next_T>cnt, next_F>cnt.
  - Output (dec==1) nodes skip the pointer check.
  - Valid record: wr_en_o=1, wr_addr_o=addr, wr_data_o=record, all in this cycle, i.e. the cycle after the 5th byte is accepted.
    - If addr==cnt, go to DONE.
    - Otherwise addr+1, idx=0, return to RECV.
  - Invalid record: wr_en_o stays 0, err_o=1, go to ERR. Nodes already written remain in RAM.
- DONE: done_o=1 for one cycle, busy_o=0, then go to IDLE.
- ERR:
  - err_o held at 1, byte_ready_o=0, busy_o=0.
  - load_start_i behaves as in IDLE: err_o clears on a valid restart.
- Throughput: minimum 6 cycles per node (5 accept cycles + 1 write cycle).
- Address range: maximum load is 2**STATE-1 nodes. Because addr never exceeds cnt, the address cannot wrap to 0.
- wr_addr_o and wr_data_o are don't-care when wr_en_o=0; the bench must check them only on strobe.

Test Plan:
- 3-node tree, cnt=3, valid held high:
  - Bytes: 00 10 02 03 00 | 01 00 00 00 AA | 01 00 00 00 55.
  - Required writes: addr1=0x0_0_10_02_03_00 (dec=0), addr2 y=0xAA dec=1, addr3 y=0x55 dec=1.
  - Writes land 6 cycles apart; done_o pulses once, 1 cycle after the 3rd write.
- Same stream as above with byte_valid_i deasserted every other cycle -> identical writes; no byte lost or duplicated.
- cnt=2, node1 bytes 00 10 02 03 00 (next_F=3>cnt) -> no write, err_o=1, state ERR. A following load_start_i with cnt=1 and bytes 01 00 00 00 07 -> err_o clears, addr1 y=0x07, done_o pulses.
- Header 0x02 in node1 -> err_o=1, wr_en_o never asserted.
- reset=0 after 3 bytes of node2 -> no write; all outputs 0 the next cycle. A fresh load then starts again at addr1.
- load_start_i with node_cnt_i=0 -> err_o=1, byte_ready_o stays 0.
